// File: rtl/atomic_counters.sv
// atomic_counters: 64-bit free-running event counter read over a 32-bit bus
// in two beats. An LSB read (req_i & atomic_i) snapshots the whole 64-bit
// count, returning the low word and holding the high word in msb_q. A later
// MSB read (req_i & ~atomic_i) returns that held word, so both beats always
// come from the same count value.
//
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous active-high reset
//   trig_i    - event strobe, +1 per sampled high edge
//   req_i     - read request
//   atomic_i  - 1: LSB read + snapshot, 0: MSB read of the snapshot
//   ack_o     - registered, high the cycle after each sampled request
//   count_o   - registered 32-bit read data
module atomic_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig_i,
  input  logic        req_i,
  input  logic        atomic_i,
  output logic        ack_o,
  output logic [31:0] count_o
);

  localparam int unsigned CntW = 64;
  localparam int unsigned BusW = 32;

  logic [CntW-1:0] count_q, count_d;
  logic [BusW-1:0] msb_q, msb_d;
  logic [BusW-1:0] data_q, data_d;
  logic            ack_q, ack_d;

  // Snapshot is taken from the post-increment value so that an event landing
  // on the same edge as the LSB read is part of the returned count.
  always_comb begin
    count_d = count_q + CntW'(trig_i);
    msb_d   = msb_q;
    data_d  = data_q;
    ack_d   = req_i;
    if (req_i) begin
      if (atomic_i) begin
        data_d = count_d[BusW-1:0];
        msb_d  = count_d[CntW-1:BusW];
      end else begin
        data_d = msb_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      msb_q   <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      msb_q   <= msb_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
    end
  end

  assign count_o = data_q;
  assign ack_o   = ack_q;

endmodule

// File: tb/tb_atomic_counters.sv
// tb_atomic_counters: directed and random stimulus for atomic_counters,
// checked against a count/snapshot reference model held in the bench.
module tb_atomic_counters;

  logic        clk;
  logic        reset;
  logic        trig_i;
  logic        req_i;
  logic        atomic_i;
  logic        ack_o;
  logic [31:0] count_o;

  int nerr = 0;
  int nchk = 0;

  // Reference model state.
  longint unsigned m_count = 0;
  longint unsigned m_msb   = 0;
  longint unsigned m_data  = 0;
  bit              m_ack   = 1'b0;

  atomic_counters dut (
    .clk      (clk),
    .reset    (reset),
    .trig_i   (trig_i),
    .req_i    (req_i),
    .atomic_i (atomic_i),
    .ack_o    (ack_o),
    .count_o  (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample edge, update model, compare #1 later.
  task automatic cycle(input bit t, input bit r, input bit a, input bit rst);
    longint unsigned nxt;
    @(negedge clk);
    trig_i   = t;
    req_i    = r;
    atomic_i = a;
    reset    = rst;
    @(posedge clk);
    if (rst) begin
      m_count = 0;
      m_msb   = 0;
      m_data  = 0;
      m_ack   = 1'b0;
    end else begin
      nxt = m_count + longint'(t);
      if (r) begin
        if (a) begin
          m_data = nxt % 64'h1_0000_0000;
          m_msb  = nxt / 64'h1_0000_0000;
        end else begin
          m_data = m_msb;
        end
      end
      m_ack   = r;
      m_count = nxt;
    end
    #1;
    check("model_count_o", 64'(count_o), m_data);
    check("model_ack_o", 64'(ack_o), 64'(m_ack));
    check("model_count_q", dut.count_q, m_count);
  endtask

  task automatic preload(input longint unsigned v);
    dut.count_q = v;
    m_count     = v;
  endtask

  initial begin
    trig_i   = 1'b0;
    req_i    = 1'b0;
    atomic_i = 1'b0;
    reset    = 1'b1;

    // Reset for 3 cycles, then a read pair of zeros.
    repeat (3) cycle(0, 0, 0, 1);
    check("rst_count_o", 64'(count_o), 64'h0);
    check("rst_ack_o", 64'(ack_o), 64'h0);
    cycle(0, 1, 1, 0);
    check("rst_lsb", 64'(count_o), 64'h0);
    check("rst_lsb_ack", 64'(ack_o), 64'h1);
    cycle(0, 1, 0, 0);
    check("rst_msb", 64'(count_o), 64'h0);

    // Lower-word counting: two triggers, idle, read pair; five times.
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 1, 1, 0);
      check("low_lsb", 64'(count_o), 64'(2 * (i + 1)));
      cycle(0, 1, 0, 0);
      check("low_msb", 64'(count_o), 64'h0);
    end

    // Parallel triggers over a 4-cycle window, snapshot on 2nd edge (C=10).
    cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 0);
    check("par_lsb", 64'(count_o), 64'd12);
    cycle(1, 1, 0, 0);
    check("par_msb", 64'(count_o), 64'h0);
    cycle(1, 0, 0, 0);
    check("par_final", dut.count_q, 64'd14);

    // Carry from bit 31 into bit 32.
    preload(64'h0000_0000_FFFF_FFFD);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    check("carry_lsb0", 64'(count_o), 64'hFFFF_FFFF);
    cycle(0, 1, 0, 0);
    check("carry_msb0", 64'(count_o), 64'h0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    check("carry_lsb1", 64'(count_o), 64'h1);
    cycle(0, 1, 0, 0);
    check("carry_msb1", 64'(count_o), 64'h1);
    cycle(0, 1, 0, 0);
    check("carry_msb_again", 64'(count_o), 64'h1);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    check("carry_msb_reread", 64'(count_o), 64'h1);

    // Atomicity: trigger on the MSB beat must not leak into the snapshot.
    preload(64'h0000_0000_FFFF_FFFF);
    cycle(0, 1, 1, 0);
    check("atom_lsb", 64'(count_o), 64'hFFFF_FFFF);
    cycle(1, 1, 0, 0);
    check("atom_msb", 64'(count_o), 64'h0);
    check("atom_live", dut.count_q, 64'h1_0000_0000);

    // 64-bit wrap, trigger coinciding with the LSB read.
    preload(64'hFFFF_FFFF_FFFF_FFFF);
    cycle(1, 1, 1, 0);
    check("wrap_lsb", 64'(count_o), 64'h0);
    cycle(0, 1, 0, 0);
    check("wrap_msb", 64'(count_o), 64'h0);
    check("wrap_live", dut.count_q, 64'h0);

    // ack_o pulses exactly once per request.
    cycle(0, 0, 0, 0);
    check("ack_idle", 64'(ack_o), 64'h0);
    cycle(0, 1, 1, 0);
    check("ack_pulse", 64'(ack_o), 64'h1);
    cycle(0, 0, 0, 0);
    check("ack_drop", 64'(ack_o), 64'h0);

    // Reset between the two beats discards the snapshot.
    preload(64'h0000_0005_0000_0000);
    cycle(1, 1, 1, 0);
    check("mid_lsb", 64'(count_o), 64'h1);
    cycle(0, 0, 0, 1);
    check("mid_rst_count_o", 64'(count_o), 64'h0);
    check("mid_rst_ack", 64'(ack_o), 64'h0);
    cycle(0, 1, 0, 0);
    check("mid_msb", 64'(count_o), 64'h0);

    // Random traffic, starting near the 64-bit wrap point.
    preload(64'hFFFF_FFFF_FFFF_FFF0);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) preload(64'h0000_0003_FFFF_FFF8);
      cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
